// File: rtl/swap_ctrl.sv
// Swap sequencer in front of a 1W/1R async-read register file: passes host
// traffic through when idle, otherwise runs read A / write A<=B / write B<=A.
module swap_ctrl #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              swap_start,
    input  logic [ADDR_W-1:0] swap_addr_a,
    input  logic [ADDR_W-1:0] swap_addr_b,
    output logic              swap_busy,
    output logic              swap_done,
    output logic [CNT_W-1:0]  swap_count,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_waddr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic [ADDR_W-1:0] host_raddr,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_address_w,
    output logic [DATA_W-1:0] rf_data_w,
    output logic [ADDR_W-1:0] rf_address_r,
    input  logic [DATA_W-1:0] rf_data_r
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        WR_A = 3'd2,
        WR_B = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_a_q;
    logic [ADDR_W-1:0] addr_b_q;
    logic [DATA_W-1:0] tmp_q;
    logic [CNT_W-1:0]  count_q;
    logic              busy_q;
    logic              done_q;
    logic              ready_q;

    // State register plus status flags registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
            ready_q <= (state_d == IDLE);
        end
    end

    // Capture swap addresses on acceptance and old A during the read phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_a_q <= '0;
            addr_b_q <= '0;
            tmp_q    <= '0;
        end else begin
            if ((state_q == IDLE) && swap_start && (swap_addr_a != swap_addr_b)) begin
                addr_a_q <= swap_addr_a;
                addr_b_q <= swap_addr_b;
            end
            if (state_q == RD_A) begin
                tmp_q <= rf_data_r;
            end
        end
    end

    // Saturating count of completed swaps, including a==b no-ops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if ((state_q == DONE) && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // Next-state and register-file port steering
    always_comb begin
        state_d      = state_q;
        rf_we        = 1'b0;
        rf_address_w = addr_a_q;
        rf_data_w    = tmp_q;
        rf_address_r = addr_a_q;
        case (state_q)
            IDLE: begin
                rf_we        = host_we;
                rf_address_w = host_waddr;
                rf_data_w    = host_wdata;
                rf_address_r = host_raddr;
                if (swap_start) begin
                    state_d = (swap_addr_a == swap_addr_b) ? DONE : RD_A;
                end
            end
            RD_A: begin
                rf_address_r = addr_a_q;
                state_d      = WR_A;
            end
            WR_A: begin
                // Old B flows straight from the async read port into A
                rf_address_r = addr_b_q;
                rf_we        = 1'b1;
                rf_address_w = addr_a_q;
                rf_data_w    = rf_data_r;
                state_d      = WR_B;
            end
            WR_B: begin
                rf_address_r = addr_b_q;
                rf_we        = 1'b1;
                rf_address_w = addr_b_q;
                rf_data_w    = tmp_q;
                state_d      = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign swap_busy  = busy_q;
    assign swap_done  = done_q;
    assign host_ready = ready_q;
    assign swap_count = count_q;
    assign host_rdata = rf_data_r;

endmodule
